wb_lockstep_miter: RTL and testbench
====================================

// Module: wb_lockstep_miter
// PURPOSE
// Sequential, skew-tolerant lockstep checker for two Wishbone masters: a reference CPU and a mutated/UUT CPU.
// Accepted request beats from each side are queued and compared in order.
// A bounded inter-side skew is tolerated; any divergence is latched and reported.
// Sits in the mutation-test miter and the formal/simulation harnesses, between the two CPU bus ports and the fault outputs.
// PARAMETERS
// AW         30  Wishbone word-address width
// DW         32  data width; select width is DW/8
// LGDEPTH    3   log2 of per-side beat FIFO depth (depth 8)
// MAX_SKEW   4   max cycles one side may hold unmatched beats (1..255)
// OPT_STRICT 0   1: beats and CYC must coincide cycle-exactly (classic lockstep)
// PORTS
// i_clk          in   1       clock
// i_reset        in   1       async active-high reset
// i_ref_cyc/stb/we  in  1 each  reference master bus controls
// i_ref_addr     in   AW      reference address
// i_ref_data     in   DW      reference write data
// i_ref_sel      in   DW/8    reference byte selects
// i_ref_stall    in   1       stall seen by reference
// i_uut_cyc/stb/we, i_uut_addr, i_uut_data, i_uut_sel, i_uut_stall   same for UUT
// o_fail         out  1       sticky divergence flag
// o_fail_cause   out  3       lsm_pkg::cause_t of first failure
// o_fail_addr    out  AW      reference-side address at first failure (0 if none)
// o_match        out  1       one-cycle strobe per matched beat pair
// o_beat_count   out  32      matched-pair count, saturating at 32'hFFFF_FFFF
// BEHAVIOUR
// Clock is i_clk. Reset is i_reset, one clock, asynchronous, active-high.
// - Reset: all outputs 0, both FIFOs empty, skew counter 0, state IDLE. Assertion mid-operation aborts everything at once.
// - Beat per side: cyc && stb && !stall. The beat pushes {we, addr, we?sel:0, we?data:0}; read beats therefore compare only we and addr.
// - Compare path:
//   - Both FIFO heads valid -> pop both in the same cycle and compare all fields.
//   - Equal -> o_match=1 next cycle, o_beat_count+1.
//   - Unequal -> FAIL with cause MISMATCH.
//   - Latency push->o_match is 1 cycle.
// - Full FIFO: a push into it is legal only when that side pops in the same cycle; otherwise FAIL with cause OVFL.
// - Skew counter:
//   - Counts while exactly one FIFO is non-empty.
//   - Clears when both are empty or a pair pops.
//   - Reaching MAX_SKEW -> FAIL with cause SKEW.
// - OPT_STRICT=1 adds two checks:
//   - ref_cyc != uut_cyc -> cause CYC.
//   - Beat present on one side only -> cause SKEW, in the same cycle.
//   - These checks take priority over MISMATCH detected on the same edge.
// - Cause priority on one edge: CYC > OVFL > SKEW > MISMATCH.
// - FSM:
//   - IDLE -> RUN on first beat from either side.
//   - RUN -> FAIL on any cause.
//   - FAIL is absorbing until reset: pushes/pops stop, o_beat_count freezes, o_match=0.
//   - o_fail, o_fail_cause and o_fail_addr are registered, valid the cycle after detection, and never overwritten.
// - o_fail_addr holds the ref head address for MISMATCH/SKEW, and i_ref_addr for CYC/OVFL.
// - FIFO pointers wrap modulo 2^LGDEPTH. Occupancy is LGDEPTH+1 bits to distinguish full from empty.
// STRUCTURE
// - lsm_pkg: cause_t enum (NONE=0, MISMATCH=1, SKEW=2, OVFL=3, CYC=4), state_t enum (IDLE, RUN, FAIL), beat_t packed struct.
// - Sub-module lsm_fifo: synchronous FIFO with show-ahead head; params WIDTH, LGDEPTH; ports i_clk, i_reset, push, pop, data, full, empty.
//   - Instanced twice, once per side.
// - Top holds the comparator, skew counter, FSM and fault capture.
// TESTING
// 1. Identical 20-beat write burst, same cycles -> 20 o_match strobes, o_beat_count=20, o_fail=0.
// 2. UUT delayed 3 cycles, MAX_SKEW=4 -> no fail. Delay 4 -> o_fail=1, cause SKEW, fail_addr = first ref addr.
// 3. Beat 5 of a write, UUT data 32'hDEAD_BEEF vs ref 32'h0 -> cause MISMATCH, count=4, fail_addr=beat-5 addr.
//    Read with differing data bus values -> no fail.
// 4. Ref issues 9 beats while UUT is stalled (LGDEPTH=3, MAX_SKEW=255) -> cause OVFL on the 9th push.
// 5. OPT_STRICT=1, UUT cyc rises 1 cycle late -> cause CYC next cycle. Same skew with OPT_STRICT=0 -> pass.
// 6. Reset asserted during FAIL and mid-burst -> all outputs 0 immediately. A fresh identical burst then passes.

Source files
------------

// File: rtl/lsm_pkg.sv
// rtl/lsm_pkg.sv - shared types for the Wishbone lockstep miter
package lsm_pkg;

    localparam int LSM_AW = 30;
    localparam int LSM_DW = 32;

    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_MISMATCH = 3'd1,
        CAUSE_SKEW     = 3'd2,
        CAUSE_OVFL     = 3'd3,
        CAUSE_CYC      = 3'd4
    } cause_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    // Reference layout of a queued beat at the default bus widths
    typedef struct packed {
        logic                  we;
        logic [LSM_AW-1:0]     addr;
        logic [LSM_DW/8-1:0]   sel;
        logic [LSM_DW-1:0]     data;
    } beat_t;

    // When several faults land on one edge, report the most fundamental one
    function automatic cause_t pick_cause(input logic cyc, input logic ovfl,
                                          input logic skew, input logic mism);
        if (cyc)       return CAUSE_CYC;
        else if (ovfl) return CAUSE_OVFL;
        else if (skew) return CAUSE_SKEW;
        else if (mism) return CAUSE_MISMATCH;
        else           return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/lsm_fifo.sv
// rtl/lsm_fifo.sv - show-ahead synchronous beat FIFO, one per bus side
module lsm_fifo #(
    parameter int WIDTH   = 8,
    parameter int LGDEPTH = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]   mem [0:(1<<LGDEPTH)-1];
    logic [LGDEPTH-1:0] wptr;
    logic [LGDEPTH-1:0] rptr;
    logic [LGDEPTH:0]   count;
    logic               do_push;
    logic               do_pop;

    // A full FIFO still accepts a push when the head leaves on the same edge
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wptr] <= data;
    end

    assign head  = mem[rptr];
    assign full  = count[LGDEPTH];
    assign empty = (count == '0);

endmodule

// File: rtl/wb_lockstep_miter.sv
// rtl/wb_lockstep_miter.sv - skew-tolerant lockstep checker for a reference and a UUT Wishbone master
module wb_lockstep_miter
    import lsm_pkg::*;
#(
    parameter int AW         = 30,
    parameter int DW         = 32,
    parameter int LGDEPTH    = 3,
    parameter int MAX_SKEW   = 4,
    parameter bit OPT_STRICT = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_ref_cyc,
    input  logic            i_ref_stb,
    input  logic            i_ref_we,
    input  logic [AW-1:0]   i_ref_addr,
    input  logic [DW-1:0]   i_ref_data,
    input  logic [DW/8-1:0] i_ref_sel,
    input  logic            i_ref_stall,
    input  logic            i_uut_cyc,
    input  logic            i_uut_stb,
    input  logic            i_uut_we,
    input  logic [AW-1:0]   i_uut_addr,
    input  logic [DW-1:0]   i_uut_data,
    input  logic [DW/8-1:0] i_uut_sel,
    input  logic            i_uut_stall,
    output logic            o_fail,
    output cause_t          o_fail_cause,
    output logic [AW-1:0]   o_fail_addr,
    output logic            o_match,
    output logic [31:0]     o_beat_count
);

    localparam int BW = 1 + AW + DW/8 + DW;

    state_t        state;
    state_t        state_next;
    logic [7:0]    skew;
    logic [8:0]    skew_inc;

    logic          ref_beat, uut_beat;
    logic          ref_push, uut_push;
    logic          active;
    logic [BW-1:0] ref_word, uut_word;
    logic [BW-1:0] ref_head, uut_head;
    logic          ref_full, uut_full;
    logic          ref_empty, uut_empty;
    logic          pair_pop;
    logic          heads_equal;
    logic          one_pending;
    logic          hit_cyc, hit_ovfl, hit_skew, hit_mism;
    cause_t        cause;
    logic [AW-1:0] cause_addr;

    assign ref_beat = i_ref_cyc && i_ref_stb && !i_ref_stall;
    assign uut_beat = i_uut_cyc && i_uut_stb && !i_uut_stall;
    assign active   = (state != ST_FAIL);
    assign ref_push = active && ref_beat;
    assign uut_push = active && uut_beat;

    // Reads carry no meaningful sel/data, so only we and addr take part in the compare
    assign ref_word = {i_ref_we, i_ref_addr,
                       i_ref_we ? i_ref_sel  : {(DW/8){1'b0}},
                       i_ref_we ? i_ref_data : {DW{1'b0}}};
    assign uut_word = {i_uut_we, i_uut_addr,
                       i_uut_we ? i_uut_sel  : {(DW/8){1'b0}},
                       i_uut_we ? i_uut_data : {DW{1'b0}}};

    lsm_fifo #(.WIDTH(BW), .LGDEPTH(LGDEPTH)) u_ref_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push    (ref_push),
        .pop     (pair_pop),
        .data    (ref_word),
        .head    (ref_head),
        .full    (ref_full),
        .empty   (ref_empty)
    );

    lsm_fifo #(.WIDTH(BW), .LGDEPTH(LGDEPTH)) u_uut_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push    (uut_push),
        .pop     (pair_pop),
        .data    (uut_word),
        .head    (uut_head),
        .full    (uut_full),
        .empty   (uut_empty)
    );

    assign pair_pop    = active && !ref_empty && !uut_empty;
    assign heads_equal = (ref_head == uut_head);
    assign one_pending = active && (ref_empty != uut_empty);
    assign skew_inc    = {1'b0, skew} + 9'd1;

    assign hit_cyc  = OPT_STRICT && active && (i_ref_cyc != i_uut_cyc);
    assign hit_ovfl = (ref_push && ref_full && !pair_pop) ||
                      (uut_push && uut_full && !pair_pop);
    assign hit_skew = (one_pending && (skew_inc >= 9'(MAX_SKEW))) ||
                      (OPT_STRICT && active && (ref_beat != uut_beat));
    assign hit_mism = pair_pop && !heads_equal;
    assign cause    = pick_cause(hit_cyc, hit_ovfl, hit_skew, hit_mism);

    always_comb begin
        cause_addr = i_ref_addr;
        if ((cause == CAUSE_MISMATCH || cause == CAUSE_SKEW) && !ref_empty)
            cause_addr = ref_head[BW-2 -: AW];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cause != CAUSE_NONE)     state_next = ST_FAIL;
                else if (ref_beat || uut_beat) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (cause != CAUSE_NONE) state_next = ST_FAIL;
            end
            default: state_next = ST_FAIL;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            skew         <= '0;
            o_fail       <= 1'b0;
            o_fail_cause <= CAUSE_NONE;
            o_fail_addr  <= '0;
            o_match      <= 1'b0;
            o_beat_count <= '0;
        end else begin
            o_match <= pair_pop && heads_equal && (cause == CAUSE_NONE);
            if (pair_pop && heads_equal && (cause == CAUSE_NONE) && (o_beat_count != 32'hFFFF_FFFF))
                o_beat_count <= o_beat_count + 32'd1;

            if (active) begin
                if (pair_pop || (ref_empty && uut_empty))
                    skew <= '0;
                else if (one_pending && (skew != 8'hFF))
                    skew <= skew_inc[7:0];
            end

            // First cause wins; the FAIL state blocks any later overwrite
            if (active && (cause != CAUSE_NONE)) begin
                o_fail       <= 1'b1;
                o_fail_cause <= cause;
                o_fail_addr  <= cause_addr;
            end
        end
    end

endmodule

// File: tb/tb_wb_lockstep_miter.sv
// tb/tb_wb_lockstep_miter.sv - directed bench for wb_lockstep_miter
module tb_wb_lockstep_miter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ref_cyc, ref_stb, ref_we, ref_stall;
    logic [29:0] ref_addr;
    logic [31:0] ref_data;
    logic [3:0]  ref_sel;
    logic        uut_cyc, uut_stb, uut_we, uut_stall;
    logic [29:0] uut_addr;
    logic [31:0] uut_data;
    logic [3:0]  uut_sel;

    logic        fail_d, fail_o, fail_s;
    logic [2:0]  cause_d, cause_o, cause_s;
    logic [29:0] addr_d, addr_o, addr_s;
    logic        match_d, match_o, match_s;
    logic [31:0] cnt_d, cnt_o, cnt_s;

    int n_cmp = 0;
    int n_bad = 0;
    int match_cnt;
    int fail_cyc_s;

    always #5 clk = ~clk;

    wb_lockstep_miter dut (
        .i_clk(clk), .i_reset(rst),
        .i_ref_cyc(ref_cyc), .i_ref_stb(ref_stb), .i_ref_we(ref_we), .i_ref_addr(ref_addr),
        .i_ref_data(ref_data), .i_ref_sel(ref_sel), .i_ref_stall(ref_stall),
        .i_uut_cyc(uut_cyc), .i_uut_stb(uut_stb), .i_uut_we(uut_we), .i_uut_addr(uut_addr),
        .i_uut_data(uut_data), .i_uut_sel(uut_sel), .i_uut_stall(uut_stall),
        .o_fail(fail_d), .o_fail_cause(cause_d), .o_fail_addr(addr_d),
        .o_match(match_d), .o_beat_count(cnt_d)
    );

    wb_lockstep_miter #(.MAX_SKEW(255)) dut_o (
        .i_clk(clk), .i_reset(rst),
        .i_ref_cyc(ref_cyc), .i_ref_stb(ref_stb), .i_ref_we(ref_we), .i_ref_addr(ref_addr),
        .i_ref_data(ref_data), .i_ref_sel(ref_sel), .i_ref_stall(ref_stall),
        .i_uut_cyc(uut_cyc), .i_uut_stb(uut_stb), .i_uut_we(uut_we), .i_uut_addr(uut_addr),
        .i_uut_data(uut_data), .i_uut_sel(uut_sel), .i_uut_stall(uut_stall),
        .o_fail(fail_o), .o_fail_cause(cause_o), .o_fail_addr(addr_o),
        .o_match(match_o), .o_beat_count(cnt_o)
    );

    wb_lockstep_miter #(.OPT_STRICT(1'b1)) dut_s (
        .i_clk(clk), .i_reset(rst),
        .i_ref_cyc(ref_cyc), .i_ref_stb(ref_stb), .i_ref_we(ref_we), .i_ref_addr(ref_addr),
        .i_ref_data(ref_data), .i_ref_sel(ref_sel), .i_ref_stall(ref_stall),
        .i_uut_cyc(uut_cyc), .i_uut_stb(uut_stb), .i_uut_we(uut_we), .i_uut_addr(uut_addr),
        .i_uut_data(uut_data), .i_uut_sel(uut_sel), .i_uut_stall(uut_stall),
        .o_fail(fail_s), .o_fail_cause(cause_s), .o_fail_addr(addr_s),
        .o_match(match_s), .o_beat_count(cnt_s)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        ref_cyc = 0; ref_stb = 0; ref_we = 0; ref_stall = 0;
        ref_addr = '0; ref_data = '0; ref_sel = '0;
        uut_cyc = 0; uut_stb = 0; uut_we = 0; uut_stall = 0;
        uut_addr = '0; uut_data = '0; uut_sel = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_bus();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // n beats on ref from cycle 0; UUT mirrors them 'delay' cycles later.
    // Beat index 'bad' carries ref data 0 and UUT data DEAD_BEEF.
    task automatic burst(input int n, input int delay, input bit we, input int bad,
                         input bit uut_stalled, input bit flip_data);
        match_cnt  = 0;
        fail_cyc_s = -1;
        for (int c = 0; c < n + delay + 4; c++) begin
            int u;
            u = c - delay;
            ref_cyc   = (c < n);
            ref_stb   = (c < n);
            ref_we    = we;
            ref_addr  = 30'(32'h100 + c);
            ref_data  = (c == bad) ? 32'h0 : 32'(32'h1000_0000 + c);
            ref_sel   = 4'hF;
            ref_stall = 1'b0;
            if (uut_stalled) begin
                uut_cyc   = (c < n);
                uut_stb   = (c < n);
                uut_stall = 1'b1;
                uut_addr  = ref_addr;
                uut_data  = ref_data;
            end else begin
                uut_cyc   = (u >= 0) && (u < n);
                uut_stb   = (u >= 0) && (u < n);
                uut_stall = 1'b0;
                uut_addr  = 30'(32'h100 + u);
                uut_data  = (u == bad) ? 32'hDEAD_BEEF :
                            (flip_data ? ~32'(32'h1000_0000 + u) : 32'(32'h1000_0000 + u));
            end
            uut_we  = we;
            uut_sel = 4'hF;
            @(posedge clk);
            #1;
            if (match_d) match_cnt++;
            if (fail_s && fail_cyc_s < 0) fail_cyc_s = c;
        end
        idle_bus();
    endtask

    initial begin
        idle_bus();
        do_reset();
        expect_eq("rst_fail",  32'(fail_d),  32'd0);
        expect_eq("rst_cause", 32'(cause_d), 32'd0);
        expect_eq("rst_addr",  32'(addr_d),  32'd0);
        expect_eq("rst_match", 32'(match_d), 32'd0);
        expect_eq("rst_count", cnt_d,        32'd0);

        burst(20, 0, 1'b1, -1, 1'b0, 1'b0);
        expect_eq("t1_matches", 32'(match_cnt), 32'd20);
        expect_eq("t1_count",   cnt_d,          32'd20);
        expect_eq("t1_fail",    32'(fail_d),    32'd0);
        expect_eq("t1_strict_fail", 32'(fail_s), 32'd0);

        do_reset();
        burst(8, 3, 1'b1, -1, 1'b0, 1'b0);
        expect_eq("t2_skew3_fail",  32'(fail_d), 32'd0);
        expect_eq("t2_skew3_count", cnt_d,       32'd8);

        do_reset();
        burst(8, 4, 1'b1, -1, 1'b0, 1'b0);
        expect_eq("t2_skew4_fail",  32'(fail_d),  32'd1);
        expect_eq("t2_skew4_cause", 32'(cause_d), 32'd2);
        expect_eq("t2_skew4_addr",  32'(addr_d),  32'h100);
        expect_eq("t2_skew4_count", cnt_d,        32'd0);

        do_reset();
        burst(8, 0, 1'b1, 4, 1'b0, 1'b0);
        expect_eq("t3_mism_fail",  32'(fail_d),  32'd1);
        expect_eq("t3_mism_cause", 32'(cause_d), 32'd1);
        expect_eq("t3_mism_count", cnt_d,        32'd4);
        expect_eq("t3_mism_addr",  32'(addr_d),  32'h104);

        do_reset();
        burst(8, 0, 1'b0, -1, 1'b0, 1'b1);
        expect_eq("t3_read_fail",  32'(fail_d), 32'd0);
        expect_eq("t3_read_count", cnt_d,       32'd8);

        do_reset();
        burst(9, 0, 1'b1, -1, 1'b1, 1'b0);
        expect_eq("t4_ovfl_fail",  32'(fail_o),  32'd1);
        expect_eq("t4_ovfl_cause", 32'(cause_o), 32'd3);
        expect_eq("t4_ovfl_addr",  32'(addr_o),  32'h108);
        expect_eq("t4_ovfl_count", cnt_o,        32'd0);

        do_reset();
        burst(4, 1, 1'b1, -1, 1'b0, 1'b0);
        expect_eq("t5_strict_fail",  32'(fail_s),     32'd1);
        expect_eq("t5_strict_cause", 32'(cause_s),    32'd4);
        expect_eq("t5_strict_addr",  32'(addr_s),     32'h100);
        expect_eq("t5_strict_when",  32'(fail_cyc_s), 32'd0);
        expect_eq("t5_loose_fail",   32'(fail_d),     32'd0);
        expect_eq("t5_loose_count",  cnt_d,           32'd4);

        // Asynchronous reset while dut_s sits in FAIL
        rst = 1'b1;
        #1;
        expect_eq("t6_failrst_fail",  32'(fail_s),  32'd0);
        expect_eq("t6_failrst_cause", 32'(cause_s), 32'd0);
        expect_eq("t6_failrst_addr",  32'(addr_s),  32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int c = 0; c < 5; c++) begin
            ref_cyc = 1; ref_stb = 1; ref_we = 1; ref_addr = 30'(32'h200 + c);
            ref_data = 32'(c); ref_sel = 4'hF;
            uut_cyc = 1; uut_stb = 1; uut_we = 1; uut_addr = 30'(32'h200 + c);
            uut_data = 32'(c); uut_sel = 4'hF;
            @(posedge clk);
            #1;
        end
        expect_eq("t6_mid_count_pre", cnt_d, 32'd4);
        rst = 1'b1;
        idle_bus();
        #1;
        expect_eq("t6_mid_count", cnt_d,          32'd0);
        expect_eq("t6_mid_match", 32'(match_d),   32'd0);
        expect_eq("t6_mid_fail",  32'(fail_d),    32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        burst(6, 0, 1'b1, -1, 1'b0, 1'b0);
        expect_eq("t6_fresh_matches", 32'(match_cnt), 32'd6);
        expect_eq("t6_fresh_count",   cnt_d,          32'd6);
        expect_eq("t6_fresh_fail",    32'(fail_d),    32'd0);
        expect_eq("t6_fresh_strict",  32'(fail_s),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
